// File: rtl/add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add_pkg
// Description : Shared definitions for the multi-word sequential adder:
//               word width, the per-operand word limit, the word-index width,
//               the sequencer state encoding and 4-bit look-ahead helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package add_pkg;

    localparam int WORD_W          = 64;
    localparam int MAX_WORDS_LIMIT = 16;
    // Wide enough to count 0..MAX_WORDS_LIMIT-1 for any legal MAX_WORDS.
    localparam int IDX_W           = $clog2(MAX_WORDS_LIMIT);

    typedef enum logic [0:0] {
        ST_FIRST = 1'b0,   // expecting word 0 of an operation
        ST_MID   = 1'b1    // expecting word 1..MAX_WORDS-1
    } state_t;

    // Group generate/propagate of a 4-wide slice: returns {G, P}.
    function automatic logic [1:0] cla4_gp(input logic [3:0] g, input logic [3:0] p);
        logic w_grp_g;
        logic w_grp_p;
        w_grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        w_grp_p = &p;
        return {w_grp_g, w_grp_p};
    endfunction

    // Carries into the four positions of a slice, all computed in parallel
    // from the slice carry-in (element 0 is the carry-in itself).
    function automatic logic [3:0] cla4_carry(input logic [3:0] g, input logic [3:0] p,
                                              input logic ci);
        logic [3:0] w_c;
        w_c[0] = ci;
        w_c[1] = g[0] | (p[0] & ci);
        w_c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        w_c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return w_c;
    endfunction

endpackage : add_pkg
`default_nettype wire

// File: rtl/carry_look_ahead_64bit.sv
`default_nettype none
// ============================================================================
// Module      : carry_look_ahead_64bit
// Description : Combinational 64-bit adder, {cout, sum} = a + b + cin, built as
//               a three-level 4-ary carry-look-ahead tree (bits -> 4-bit
//               groups -> 16-bit blocks -> word) so no carry ripples.
// Ports       : a, b  [63:0] in  - addends
//               cin         in  - carry-in
//               sum   [63:0] out - result word
//               cout        out - carry-out of bit 63
// Revision    : 1.0 - initial release
// ============================================================================
module carry_look_ahead_64bit
    import add_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout
);

    logic [WORD_W-1:0] w_g;
    logic [WORD_W-1:0] w_p;
    logic [WORD_W-1:0] w_c;
    logic [15:0]       w_grp_g;
    logic [15:0]       w_grp_p;
    logic [15:0]       w_grp_c;
    logic [3:0]        w_blk_g;
    logic [3:0]        w_blk_p;
    logic [3:0]        w_blk_c;
    logic              w_top_g;
    logic              w_top_p;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Level 1: 4-bit groups produce G/P upward and bit carries downward.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_grp
            assign {w_grp_g[gi], w_grp_p[gi]} = cla4_gp(w_g[4*gi +: 4], w_p[4*gi +: 4]);
            assign w_c[4*gi +: 4] = cla4_carry(w_g[4*gi +: 4], w_p[4*gi +: 4], w_grp_c[gi]);
        end
    endgenerate

    // Level 2: 16-bit blocks of four groups.
    generate
        for (genvar bi = 0; bi < 4; bi++) begin : g_blk
            assign {w_blk_g[bi], w_blk_p[bi]} = cla4_gp(w_grp_g[4*bi +: 4], w_grp_p[4*bi +: 4]);
            assign w_grp_c[4*bi +: 4] = cla4_carry(w_grp_g[4*bi +: 4], w_grp_p[4*bi +: 4],
                                                   w_blk_c[bi]);
        end
    endgenerate

    // Level 3: whole word.
    assign w_blk_c            = cla4_carry(w_blk_g, w_blk_p, cin);
    assign {w_top_g, w_top_p} = cla4_gp(w_blk_g, w_blk_p);

    assign sum  = w_p ^ w_c;
    assign cout = w_top_g | (w_top_p & cin);

endmodule : carry_look_ahead_64bit
`default_nettype wire

// File: rtl/multiword_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : multiword_add_seq
// Description : Streams multi-word operands (least-significant word first),
//               one word per cycle, through a 64-bit CLA adder, chaining the
//               carry between words. One registered output stage with
//               valid/ready flow control. Operations that exceed MAX_WORDS
//               words are cut off at the limit and flagged on err_overlen.
// Ports       : clk, rst          - clock, async active-high reset
//               in_valid/in_ready - input beat handshake
//               in_a, in_b [63:0] - operand words
//               in_cin            - carry-in, used on word 0 only
//               in_last           - most-significant word marker
//               out_valid/out_ready - output handshake
//               out_sum [63:0]    - result word
//               out_last          - final word of the result
//               out_cout          - final carry-out (0 unless out_last)
//               err_overlen       - one-cycle pulse on forced termination
// Revision    : 1.0 - initial release
// ============================================================================
module multiword_add_seq
    import add_pkg::*;
#(
    parameter int MAX_WORDS = 4   // legal range 1..16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_a,
    input  logic [WORD_W-1:0] in_b,
    input  logic              in_cin,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_sum,
    output logic              out_last,
    output logic              out_cout,
    output logic              err_overlen
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(MAX_WORDS - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_word_idx;
    logic [IDX_W-1:0]  w_word_idx_nxt;
    logic              r_carry;
    logic              w_carry_nxt;

    logic              r_out_valid;
    logic [WORD_W-1:0] r_out_sum;
    logic              r_out_last;
    logic              r_out_cout;
    logic              r_err;

    logic              w_accept;
    logic              w_add_cin;
    logic [WORD_W-1:0] w_sum;
    logic              w_cout;
    logic              w_at_limit;
    logic              w_end;
    logic              w_forced;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    assign w_add_cin = (r_state == ST_FIRST) ? in_cin : r_carry;

    carry_look_ahead_64bit u_cla (
        .a    (in_a),
        .b    (in_b),
        .cin  (w_add_cin),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // The index is 0 in FIRST, so this also covers MAX_WORDS == 1, where
    // word 0 is already the last permitted word.
    assign w_at_limit = (r_word_idx == c_last_idx);
    assign w_end      = in_last || w_at_limit;
    assign w_forced   = !in_last && w_at_limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_FIRST;
            r_word_idx <= '0;
            r_carry    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_word_idx <= w_word_idx_nxt;
            r_carry    <= w_carry_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_word_idx_nxt = r_word_idx;
        w_carry_nxt    = r_carry;
        if (w_accept) begin
            if (w_end) begin
                w_state_nxt    = ST_FIRST;
                w_word_idx_nxt = '0;
                w_carry_nxt    = 1'b0;
            end else begin
                w_state_nxt    = ST_MID;
                w_word_idx_nxt = r_word_idx + IDX_W'(1);
                w_carry_nxt    = w_cout;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_last  <= 1'b0;
            r_out_cout  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // Not gated by out_ready so the flag stays a single-cycle pulse.
            r_err <= w_accept && w_forced;
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_sum   <= w_sum;
                r_out_last  <= w_end;
                r_out_cout  <= w_end && w_cout;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_sum     = r_out_sum;
    assign out_last    = r_out_last;
    assign out_cout    = r_out_cout;
    assign err_overlen = r_err;

endmodule : multiword_add_seq
`default_nettype wire

// File: tb/tb_multiword_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_multiword_add_seq
// Description : Directed self-checking bench for multiword_add_seq
//               (MAX_WORDS = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multiword_add_seq;

    localparam logic [63:0] c_ones = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        in_cin;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic        out_last;
    logic        out_cout;
    logic        err_overlen;

    int n_checks = 0;
    int n_fail   = 0;

    multiword_add_seq #(.MAX_WORDS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_cin      (in_cin),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_last    (out_last),
        .out_cout    (out_cout),
        .err_overlen (err_overlen)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one beat and let it be taken on the next rising edge; the
    // outputs read afterwards belong to this beat.
    task automatic beat(input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic last);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_last  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Observed/expected packing: {valid, last, cout, err, sum}
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_last = 1'b0;
        #12;
        n_checks++;
        if ({out_valid, out_last, out_cout, err_overlen, out_sum, in_ready} !== {4'b0000, 64'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_hold: got v/l/c/e=%b%b%b%b sum=%h rdy=%b, need 0000 sum=0 rdy=1",
                     out_valid, out_last, out_cout, err_overlen, out_sum, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_release: got valid=%b rdy=%b, need valid=0 rdy=1", out_valid, in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_word();
        beat(c_ones, 64'h1, 1'b0, 1'b1);
        n_checks++;
        if ({out_valid, out_last, out_cout, err_overlen, out_sum} !== {4'b1110, 64'h0}) begin
            n_fail++;
            $display("FAIL single_word: got v/l/c/e=%b%b%b%b sum=%h, need 1110 sum=0",
                     out_valid, out_last, out_cout, err_overlen, out_sum);
        end
        idle();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_drain: got valid=%b, need 0", out_valid);
        end
    endtask

    task automatic test_chain128();
        beat(c_ones, 64'h1, 1'b0, 1'b0);
        n_checks++;
        if ({out_valid, out_last, out_cout, out_sum} !== {3'b100, 64'h0}) begin
            n_fail++;
            $display("FAIL chain_w0: got v/l/c=%b%b%b sum=%h, need 100 sum=0",
                     out_valid, out_last, out_cout, out_sum);
        end
        beat(64'h0, 64'h0, 1'b0, 1'b1);
        n_checks++;
        if ({out_valid, out_last, out_cout, out_sum} !== {3'b110, 64'h1}) begin
            n_fail++;
            $display("FAIL chain_w1: got v/l/c=%b%b%b sum=%h, need 110 sum=1",
                     out_valid, out_last, out_cout, out_sum);
        end
        idle();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        beat(64'd5, 64'd6, 1'b0, 1'b0);
        n_checks++;
        if ({out_valid, out_last, in_ready, out_sum} !== {3'b100, 64'd11}) begin
            n_fail++;
            $display("FAIL bp_first: got v/l/rdy=%b%b%b sum=%h, need 100 sum=b",
                     out_valid, out_last, in_ready, out_sum);
        end
        in_a = 64'd7; in_b = 64'd8;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({out_valid, out_last, in_ready, out_sum} !== {3'b100, 64'd11}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v/l/rdy=%b%b%b sum=%h, need 100 sum=b",
                         i, out_valid, out_last, in_ready, out_sum);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release_ready: got %b, need 1", in_ready);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({out_valid, out_last, out_sum} !== {2'b10, 64'd15}) begin
            n_fail++;
            $display("FAIL bp_w1: got v/l=%b%b sum=%h, need 10 sum=f", out_valid, out_last, out_sum);
        end
        beat(64'd1, 64'd2, 1'b0, 1'b1);
        n_checks++;
        if ({out_valid, out_last, out_cout, out_sum} !== {3'b110, 64'd3}) begin
            n_fail++;
            $display("FAIL bp_w2: got v/l/c=%b%b%b sum=%h, need 110 sum=3",
                     out_valid, out_last, out_cout, out_sum);
        end
        idle();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: got valid=%b, need 0", out_valid);
        end
    endtask

    task automatic test_overlength();
        logic [63:0] a_v [5];
        logic [63:0] b_v [5];
        logic [63:0] s_v [5];
        logic [3:0]  f_v [5];   // {valid, last, cout, err}
        a_v = '{c_ones, 64'h0, c_ones, c_ones, 64'h0};
        b_v = '{64'h1,  64'h0, c_ones, 64'h0,  64'h0};
        s_v = '{64'h0,  64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 64'h1};
        f_v = '{4'b1000, 4'b1000, 4'b1000, 4'b1111, 4'b1100};
        for (int i = 0; i < 5; i++) begin
            beat(a_v[i], b_v[i], (i == 4), (i == 4));
            n_checks++;
            if ({out_valid, out_last, out_cout, err_overlen, out_sum} !== {f_v[i], s_v[i]}) begin
                n_fail++;
                $display("FAIL overlen_w%0d: got v/l/c/e=%b%b%b%b sum=%h, need %b sum=%h",
                         i, out_valid, out_last, out_cout, err_overlen, out_sum, f_v[i], s_v[i]);
            end
        end
        idle();
    endtask

    task automatic test_reset_midop();
        beat(c_ones, 64'h1, 1'b0, 1'b0);
        beat(c_ones, 64'h0, 1'b0, 1'b0);
        n_checks++;
        if ({out_valid, out_last, out_sum} !== {2'b10, 64'h0}) begin
            n_fail++;
            $display("FAIL rstmid_w1: got v/l=%b%b sum=%h, need 10 sum=0", out_valid, out_last, out_sum);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, out_last, out_cout, err_overlen, out_sum, in_ready} !== {4'b0000, 64'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL rstmid_clear: got v/l/c/e=%b%b%b%b sum=%h rdy=%b, need 0000 sum=0 rdy=1",
                     out_valid, out_last, out_cout, err_overlen, out_sum, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        beat(64'h0, 64'h0, 1'b0, 1'b1);
        n_checks++;
        if ({out_valid, out_last, out_cout, out_sum} !== {3'b110, 64'h0}) begin
            n_fail++;
            $display("FAIL rstmid_fresh: got v/l/c=%b%b%b sum=%h, need 110 sum=0",
                     out_valid, out_last, out_cout, out_sum);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [64:0] t;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        carry;
        logic [63:0] exp_sum;
        logic        exp_last;
        logic        exp_cout;
        carry = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int w = 0; w < 2; w++) begin
                if (w == 0) begin
                    a   = c_ones - 64'(k);
                    b   = 64'(3 * k);
                    cin = k[0];
                    t   = {1'b0, a} + {1'b0, b} + 65'(cin);
                end else begin
                    a   = 64'h0123_4567_89AB_CDEF * 64'(k + 1);
                    b   = k[1] ? 64'(k) : ~a;
                    cin = 1'b0;
                    t   = {1'b0, a} + {1'b0, b} + 65'(carry);
                end
                exp_sum  = t[63:0];
                exp_last = (w == 1);
                exp_cout = (w == 1) && t[64];
                carry    = t[64];
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_ready op%0d w%0d: got %b, need 1", k, w, in_ready);
                end
                beat(a, b, cin, (w == 1));
                n_checks++;
                if ({out_valid, out_last, out_cout, err_overlen, out_sum} !==
                    {1'b1, exp_last, exp_cout, 1'b0, exp_sum}) begin
                    n_fail++;
                    $display("FAIL b2b op%0d w%0d: got v/l/c/e=%b%b%b%b sum=%h, need 1%b%b0 sum=%h",
                             k, w, out_valid, out_last, out_cout, err_overlen, out_sum,
                             exp_last, exp_cout, exp_sum);
                end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_chain128();
        test_backpressure();
        test_overlength();
        test_reset_midop();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_multiword_add_seq
`default_nettype wire

// File: doc/multiword_add_seq.md
MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 4: maximum 64-bit words per operand; legal range 1..16.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1: input beat valid.
REQ-005 SHALL have port in_ready, output, 1: block accepts a beat when in_valid && in_ready.
REQ-006 SHALL have port in_a, input, 64: operand A word, least-significant word first.
REQ-007 SHALL have port in_b, input, 64: operand B word, same ordering.
REQ-008 SHALL have port in_cin, input, 1: carry-in; sampled only on the first word of an operation.
REQ-009 SHALL have port in_last, input, 1: marks the most-significant word.
REQ-010 SHALL have port out_valid, output, 1: result word valid.
REQ-011 SHALL have port out_ready, input, 1: downstream accepts when out_valid && out_ready.
REQ-012 SHALL have port out_sum, output, 64: result word.
REQ-013 SHALL have port out_last, output, 1: result word is the final word.
REQ-014 SHALL have port out_cout, output, 1: final carry-out; meaningful only when out_last=1, else 0.
REQ-015 SHALL have port err_overlen, output, 1: one-cycle pulse on a forced termination.

Function
REQ-016 SHALL compute {cout, sum} = a + b + cin per word with a 64-bit carry-look-ahead adder; no ripple across 64 bits.
REQ-017 SHALL feed the adder cin = in_cin in state FIRST and the registered carry_q in state MID.
REQ-018 SHALL have states FIRST (expecting word 0) and MID (expecting word 1..MAX_WORDS-1).
REQ-019 On an accepted beat in FIRST: if in_last=0 and MAX_WORDS>1, go to MID; else stay in FIRST.
REQ-020 On an accepted beat in MID: stay in MID while in_last=0 and word_idx<MAX_WORDS-1; else return to FIRST.
REQ-021 SHALL update carry_q with the adder cout on every accepted beat, and clear it on the return to FIRST.
REQ-022 SHALL keep word_idx at 0 in FIRST and increment it per accepted beat in MID; it never exceeds MAX_WORDS-1.
REQ-023 SHALL register results with latency 1: a beat accepted in cycle N appears on out_* in cycle N+1.
REQ-024 SHALL drive in_ready = !out_valid || out_ready, so the single output register never drops or overwrites data.
REQ-025 SHALL hold out_sum, out_last and out_cout stable while out_valid=1 and out_ready=0.
REQ-026 SHALL sustain one word per cycle when in_valid=out_ready=1 continuously, including back-to-back operations.
REQ-027 Forced termination: a beat at word_idx=MAX_WORDS-1 with in_last=0 SHALL set out_last=1, drive out_cout, pulse err_overlen in the output cycle, and return to FIRST.
REQ-028 After a forced termination, the next beat SHALL start a new operation using in_cin.
REQ-029 SHALL set out_valid=0 in the cycle after out_valid && out_ready when no new beat is accepted.

Reset
REQ-030 While rst=1, SHALL hold out_valid=0, out_sum=0, out_last=0, out_cout=0, err_overlen=0, carry_q=0, word_idx=0 and state=FIRST, independent of clk.
REQ-031 SHALL discard any partial operation on reset mid-operation; the first beat after release is word 0.
REQ-032 in_ready SHALL be 1 during and immediately after reset.

Structure
REQ-033 SHALL place the state enum (FIRST, MID), WORD_W=64 and the MAX_WORDS limit of 16 in a shared package, add_pkg.
REQ-034 SHALL instantiate exactly one sub-module, carry_look_ahead_64bit (a, b, cin, sum, cout), as the datapath adder.

Verification
REQ-035 Single word: a=FFFF_FFFF_FFFF_FFFF, b=1, cin=0, last=1 -> next cycle sum=0, out_last=1, out_cout=1.
REQ-036 128-bit chain: w0 a=FFFF_FFFF_FFFF_FFFF, b=1, cin=0; w1 a=0, b=0, last -> sums 0 then 1; out_cout=0; carry propagated via carry_q.
REQ-037 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_* stable; after release, every word delivered once and in order.
REQ-038 Overlength with MAX_WORDS=4: 5 beats, last only on the 5th -> 4th result has out_last=1 and err_overlen pulses; 5th is a fresh operation using in_cin=1 (a=b=0 gives sum=1).
REQ-039 Reset mid-op: assert rst after word 1 of 3 (carry_q=1) -> outputs clear immediately; next beat a=b=0, cin=0 gives sum=0.
REQ-040 Throughput: 8 back-to-back 2-word operations with in_valid=out_ready=1 -> 16 results in 16 consecutive cycles, checked against a reference model.
